// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: debounces the centre button and turns each accepted press into
// one RAM transaction (write+readback or read), then latches the returned word
// onto the LEDs. Define RAM_CTRL_CLEAR_EN to add a CLEAR sequence that zeroes
// every RAM word when the press is taken with sw_clr=1.

module ram_port_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ADDR_W          = 6,
  parameter int DATA_W          = 8,
  parameter int DEPTH           = 64,
  parameter int READ_LAT        = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_i,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              sw_we,
  input  logic              sw_clr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [31:0]       ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic [15:0]       led,
  output logic              busy
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int CLR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_READBACK,
    S_WAIT,
    S_CAPTURE
`ifdef RAM_CTRL_CLEAR_EN
    , S_CLEAR
`endif
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic               r_levelD;
  logic [DB_W-1:0]    r_dbCnt;
  logic               w_press;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  logic               r_we;
  logic [LAT_W-1:0]   r_latCnt;
  logic [15:0]        r_led;
  logic               w_unused;

  // Upper read-data bits never reach the LEDs; sw_clr only matters with the clear option.
  assign w_unused = ^{ram_dout[31:16], sw_clr};

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_i;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new button level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_dbCnt <= '0;
    end else if (r_sync2 == r_level) begin
      r_dbCnt <= '0;
    end else if (r_dbCnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      r_level <= ~r_level;
      r_dbCnt <= '0;
    end else begin
      r_dbCnt <= r_dbCnt + 1'b1;
    end
  end

  // Delayed copy of the accepted level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_levelD <= 1'b0;
    end else begin
      r_levelD <= r_level;
    end
  end

  assign w_press = r_level & ~r_levelD;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Snapshot the switches on an accepted press so mid-transaction changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_data <= '0;
      r_we   <= 1'b0;
    end else if (r_state == S_IDLE && w_press) begin
      r_addr <= sw_addr;
      r_data <= sw_data;
      r_we   <= sw_we;
    end
  end

  // Read-latency down-counter, reloaded whenever the FSM is outside WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_latCnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_latCnt <= LAT_W'(READ_LAT - 1);
    end else if (r_latCnt != '0) begin
      r_latCnt <= r_latCnt - 1'b1;
    end
  end

`ifdef RAM_CTRL_CLEAR_EN
  logic [CLR_W-1:0] r_clrCnt;
  logic             w_clrLast;

  // Walks the clear address through 0..DEPTH-1, one word per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clrCnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clrCnt <= r_clrCnt + 1'b1;
    end else begin
      r_clrCnt <= '0;
    end
  end

  assign w_clrLast = (r_clrCnt == CLR_W'(DEPTH - 1));
`else
  logic [CLR_W-1:0] w_unusedDepth;
  assign w_unusedDepth = CLR_W'(DEPTH - 1);
`endif

  // LED register: loads read data in CAPTURE, zeroed at the end of a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_led <= ram_dout[15:0];
`ifdef RAM_CTRL_CLEAR_EN
    end else if (r_state == S_CLEAR && w_clrLast) begin
      r_led <= '0;
`endif
    end
  end

  assign led = r_led;

  // Next-state and RAM port drive; enables are single-cycle per access state.
  always_comb begin
    w_next   = r_state;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = 32'(r_addr);
    ram_din  = 32'(r_data);
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_press) begin
`ifdef RAM_CTRL_CLEAR_EN
          w_next = sw_clr ? S_CLEAR : S_ACCESS;
`else
          w_next = S_ACCESS;
`endif
        end
      end
      S_ACCESS: begin
        ram_en = 1'b1;
        ram_we = r_we;
        w_next = r_we ? S_READBACK : S_WAIT;
      end
      S_READBACK: begin
        ram_en = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (r_latCnt == '0) begin
          w_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_next = S_IDLE;
      end
`ifdef RAM_CTRL_CLEAR_EN
      S_CLEAR: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = 32'(r_clrCnt);
        ram_din  = '0;
        if (w_clrLast) begin
          w_next = S_IDLE;
        end
      end
`endif
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb_ram_port_ctrl: drives two ram_port_ctrl instances (READ_LAT=1 and READ_LAT=12)
// from the same board inputs, each with its own behavioural 64x32 RAM, and checks
// RAM port traffic, busy length and LED values against a transaction-level model.

module tb_ram_port_ctrl;

   localparam int DB    = 4;
   localparam int RL_A  = 1;
   localparam int RL_B  = 12;
   localparam int DEPTH = 64;
   localparam int NV    = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn = 1'b0;
   logic [5:0] swAddr = '0;
   logic [7:0] swData = '0;
   logic swWe = 1'b0;
   logic swClr = 1'b0;

   logic [1:0] ramEn;
   logic [1:0] ramWe;
   logic [1:0] busy;
   logic [1:0][31:0] ramAddr;
   logic [1:0][31:0] ramDin;
   logic [1:0][15:0] led;
   logic [31:0] doutA = '0;
   logic [31:0] doutB;
   logic [31:0] memA [DEPTH];
   logic [31:0] memB [DEPTH];
   logic [31:0] pipeB [RL_B];

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] din;
   } txn_t;

   typedef struct {
      logic [5:0]  addr;
      logic [7:0]  data;
      bit          we;
      bit          clr;
      logic [15:0] expLed;
   } vec_t;

   txn_t        txq [2][$];
   int          busyLen [2][$];
   logic [15:0] ledFall [2][$];
   bit          ledEarly [2];
   bit          weAlone [2];
   int          lenCnt [2];
   logic [15:0] ledHold [2];
   logic [31:0] modelMem [DEPTH];
   vec_t        vecs [NV];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   ram_port_ctrl #(.DEBOUNCE_CYCLES(DB), .ADDR_W(6), .DATA_W(8), .DEPTH(DEPTH), .READ_LAT(RL_A)) dutA (
      .clk(clk), .rst_n(rst_n), .btn_i(btn),
      .sw_addr(swAddr), .sw_data(swData), .sw_we(swWe), .sw_clr(swClr),
      .ram_en(ramEn[0]), .ram_we(ramWe[0]), .ram_addr(ramAddr[0]), .ram_din(ramDin[0]),
      .ram_dout(doutA), .led(led[0]), .busy(busy[0])
   );

   ram_port_ctrl #(.DEBOUNCE_CYCLES(DB), .ADDR_W(6), .DATA_W(8), .DEPTH(DEPTH), .READ_LAT(RL_B)) dutB (
      .clk(clk), .rst_n(rst_n), .btn_i(btn),
      .sw_addr(swAddr), .sw_data(swData), .sw_we(swWe), .sw_clr(swClr),
      .ram_en(ramEn[1]), .ram_we(ramWe[1]), .ram_addr(ramAddr[1]), .ram_din(ramDin[1]),
      .ram_dout(doutB), .led(led[1]), .busy(busy[1])
   );

   // Single-port RAM with one cycle of read latency for instance A.
   always @(posedge clk) begin
      if (ramEn[0]) begin
         if (ramWe[0]) memA[ramAddr[0][5:0]] <= ramDin[0];
         else doutA <= memA[ramAddr[0][5:0]];
      end
   end

   // Same RAM for instance B, with the read word delayed through a RL_B-deep pipe.
   always @(posedge clk) begin
      if (ramEn[1] && ramWe[1]) memB[ramAddr[1][5:0]] <= ramDin[1];
      if (ramEn[1] && !ramWe[1]) pipeB[0] <= memB[ramAddr[1][5:0]];
      for (int k = 1; k < RL_B; k++) pipeB[k] <= pipeB[k-1];
   end

   assign doutB = pipeB[RL_B-1];

   // Observer: logs every RAM access, busy window length and LED value when busy drops.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            lenCnt[i] = 0;
         end else begin
            if (ramWe[i] && !ramEn[i]) weAlone[i] = 1'b1;
            if (ramEn[i]) begin
               txn_t t;
               t.addr = ramAddr[i];
               t.we   = ramWe[i];
               t.din  = ramDin[i];
               txq[i].push_back(t);
            end
            if (busy[i]) begin
               if (lenCnt[i] == 0) ledHold[i] = led[i];
               else if (led[i] !== ledHold[i]) ledEarly[i] = 1'b1;
               lenCnt[i]++;
            end else if (lenCnt[i] != 0) begin
               busyLen[i].push_back(lenCnt[i]);
               ledFall[i].push_back(led[i]);
               lenCnt[i] = 0;
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic clearObs();
      for (int i = 0; i < 2; i++) begin
         txq[i].delete();
         busyLen[i].delete();
         ledFall[i].delete();
         ledEarly[i] = 1'b0;
         weAlone[i] = 1'b0;
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("%s_d%0d_ram_en", tag, i), 32'(ramEn[i]), 0);
         checkOutput($sformatf("%s_d%0d_ram_we", tag, i), 32'(ramWe[i]), 0);
         checkOutput($sformatf("%s_d%0d_ram_addr", tag, i), ramAddr[i], 0);
         checkOutput($sformatf("%s_d%0d_ram_din", tag, i), ramDin[i], 0);
         checkOutput($sformatf("%s_d%0d_led", tag, i), 32'(led[i]), 0);
         checkOutput($sformatf("%s_d%0d_busy", tag, i), 32'(busy[i]), 0);
      end
   endtask

   task automatic waitIdle();
      for (int k = 0; k < 400 && busy != 2'b00; k++) @(negedge clk);
      checkOutput("idle_reached", 32'(busy), 0);
      repeat (10) @(negedge clk);
   endtask

   // Hold the button 10 cycles with the given switches; scramble the switches once busy.
   task automatic applyStimulus(input logic [5:0] a, input logic [7:0] d, input bit w, input bit c);
      bit scrambled = 1'b0;
      @(negedge clk);
      swAddr = a; swData = d; swWe = w; swClr = c; btn = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (busy[0] && !scrambled) begin
            swAddr = 6'($urandom);
            swData = 8'($urandom);
            swWe = 1'($urandom);
            scrambled = 1'b1;
         end
      end
      btn = 1'b0;
      waitIdle();
   endtask

   // Reference behaviour of one accepted press: RAM update and resulting LED value.
   task automatic modelApply(input logic [5:0] a, input logic [7:0] d, input bit w, input bit c,
                             output logic [15:0] ledOut);
`ifdef RAM_CTRL_CLEAR_EN
      if (c) begin
         foreach (modelMem[k]) modelMem[k] = '0;
         ledOut = '0;
         return;
      end
`else
      if (c) ledOut = 'x;
`endif
      if (w) modelMem[a] = {24'h0, d};
      ledOut = modelMem[a][15:0];
   endtask

   task automatic checkDut(input int i, input logic [5:0] a, input logic [7:0] d, input bit w,
                           input bit c, input logic [15:0] expLed);
      string p;
      int    nExp;
      int    lenExp;
      bit    clrMode = 1'b0;
      p = (i == 0) ? "A" : "B";
      nExp = w ? 2 : 1;
      lenExp = (w ? 3 : 2) + ((i == 0) ? RL_A : RL_B);
`ifdef RAM_CTRL_CLEAR_EN
      if (c) begin
         clrMode = 1'b1;
         nExp = DEPTH;
         lenExp = DEPTH;
      end
`endif
      checkOutput({p, "_txn_count"}, txq[i].size(), nExp);
      for (int k = 0; k < txq[i].size() && k < nExp; k++) begin
         logic [31:0] eAddr;
         logic [31:0] eDin;
         logic        eWe;
         if (clrMode) begin
            eAddr = 32'(k); eWe = 1'b1; eDin = '0;
         end else begin
            eAddr = {26'h0, a}; eWe = (k == 0) ? w : 1'b0; eDin = {24'h0, d};
         end
         checkOutput($sformatf("%s_txn%0d_addr", p, k), txq[i][k].addr, eAddr);
         checkOutput($sformatf("%s_txn%0d_we", p, k), 32'(txq[i][k].we), 32'(eWe));
         checkOutput($sformatf("%s_txn%0d_din", p, k), txq[i][k].din, eDin);
      end
      checkOutput({p, "_busy_windows"}, busyLen[i].size(), 1);
      if (busyLen[i].size() > 0) checkOutput({p, "_busy_len"}, busyLen[i][0], lenExp);
      if (ledFall[i].size() > 0) checkOutput({p, "_led_at_done"}, 32'(ledFall[i][0]), 32'(expLed));
      checkOutput({p, "_led_now"}, 32'(led[i]), 32'(expLed));
      checkOutput({p, "_led_early"}, 32'(ledEarly[i]), 0);
      checkOutput({p, "_we_without_en"}, 32'(weAlone[i]), 0);
   endtask

   initial begin
      logic [15:0] mLed;
      logic [5:0]  ra;
      logic [7:0]  rd;
      bit          rw;

      vecs[0] = '{6'd5,  8'hA7, 1'b1, 1'b0, 16'h00A7};
      vecs[1] = '{6'd5,  8'h00, 1'b0, 1'b0, 16'h00A7};
      vecs[2] = '{6'd63, 8'hFF, 1'b1, 1'b0, 16'h00FF};
      vecs[3] = '{6'd0,  8'h01, 1'b1, 1'b0, 16'h0001};
      vecs[4] = '{6'd63, 8'h3C, 1'b0, 1'b0, 16'h00FF};
      vecs[5] = '{6'd0,  8'h00, 1'b0, 1'b0, 16'h0001};
`ifdef RAM_CTRL_CLEAR_EN
      vecs[6] = '{6'd5,  8'h55, 1'b0, 1'b1, 16'h0000};
      vecs[7] = '{6'd5,  8'h00, 1'b0, 1'b0, 16'h0000};
`else
      vecs[6] = '{6'd5,  8'h55, 1'b0, 1'b1, 16'h00A7};
      vecs[7] = '{6'd5,  8'h00, 1'b0, 1'b0, 16'h00A7};
`endif
      foreach (modelMem[k]) modelMem[k] = '0;
      foreach (memA[k]) begin
         memA[k] = '0;
         memB[k] = '0;
      end
      foreach (pipeB[k]) pipeB[k] = '0;

      #2;
      checkResetOutputs("por");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      for (int v = 0; v < NV; v++) begin
         clearObs();
         applyStimulus(vecs[v].addr, vecs[v].data, vecs[v].we, vecs[v].clr);
         modelApply(vecs[v].addr, vecs[v].data, vecs[v].we, vecs[v].clr, mLed);
         checkDut(0, vecs[v].addr, vecs[v].data, vecs[v].we, vecs[v].clr, vecs[v].expLed);
         checkDut(1, vecs[v].addr, vecs[v].data, vecs[v].we, vecs[v].clr, vecs[v].expLed);
      end

      $display("[TB] reset during WAIT");
      clearObs();
      @(negedge clk);
      swAddr = 6'd63; swData = 8'h00; swWe = 1'b0; swClr = 1'b0; btn = 1'b1;
      for (int k = 0; k < 20 && !busy[0]; k++) @(negedge clk);
      checkOutput("rst_reached_access", 32'(busy[0]), 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 checkResetOutputs("rst_mid_wait");
      @(negedge clk);
      btn = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      clearObs();
      applyStimulus(6'd63, 8'h00, 1'b0, 1'b0);
      modelApply(6'd63, 8'h00, 1'b0, 1'b0, mLed);
      checkDut(0, 6'd63, 8'h00, 1'b0, 1'b0, mLed);
      checkDut(1, 6'd63, 8'h00, 1'b0, 1'b0, mLed);

      $display("[TB] glitch and bounce");
      clearObs();
      @(negedge clk);
      btn = 1'b1; repeat (3) @(negedge clk);
      btn = 1'b0; repeat (2) @(negedge clk);
      btn = 1'b1; @(negedge clk);
      btn = 1'b0; @(negedge clk);
      btn = 1'b1; @(negedge clk);
      btn = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("glitch_A_txn", txq[0].size(), 0);
      checkOutput("glitch_B_txn", txq[1].size(), 0);
      checkOutput("glitch_A_busy", busyLen[0].size(), 0);
      checkOutput("glitch_B_busy", busyLen[1].size(), 0);

      $display("[TB] second press while busy");
      clearObs();
      @(negedge clk);
      swAddr = 6'd10; swData = 8'h5A; swWe = 1'b1; swClr = 1'b0; btn = 1'b1;
      repeat (6) @(negedge clk);
      btn = 1'b0;
      repeat (5) @(negedge clk);
      btn = 1'b1;
      repeat (6) @(negedge clk);
      btn = 1'b0;
      waitIdle();
      modelApply(6'd10, 8'h5A, 1'b1, 1'b0, mLed);
      checkOutput("drop_B_txn", txq[1].size(), 2);
      checkOutput("drop_B_windows", busyLen[1].size(), 1);
      if (busyLen[1].size() > 0) checkOutput("drop_B_len", busyLen[1][0], 3 + RL_B);
      checkOutput("drop_A_txn", txq[0].size(), 4);
      checkOutput("drop_A_windows", busyLen[0].size(), 2);
      checkOutput("drop_A_led", 32'(led[0]), 32'(mLed));
      checkOutput("drop_B_led", 32'(led[1]), 32'(mLed));

      $display("[TB] random transactions");
      for (int n = 0; n < 24; n++) begin
         ra = 6'($urandom_range(0, 15));
         rd = 8'($urandom);
         rw = 1'($urandom);
         clearObs();
         applyStimulus(ra, rd, rw, 1'b0);
         modelApply(ra, rd, rw, 1'b0, mLed);
         checkDut(0, ra, rd, rw, 1'b0, mLed);
         checkDut(1, ra, rd, rw, 1'b0, mLed);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
